soc_sysid_v2: RTL and testbench

Parametrised system-identification peripheral on the SoC Avalon-MM interconnect. Software reads it to confirm the FPGA image matches the software build. It supplies an ID and a build timestamp, plus a version word, a feature word, user build-info words, a read/write scratch register and an optional 64-bit uptime counter. Reads use a registered pipeline with one-cycle fixed latency, signalled by `readdatavalid`.

---
 rtl/soc_sysid_pkg.sv | 27 ++
 rtl/soc_sysid_uptime.sv | 33 +++
 rtl/soc_sysid_v2.sv | 101 ++++++++++
 tb/tb_soc_sysid_v2.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/soc_sysid_pkg.sv
// Shared register map, FEATURES layout and helpers for the soc_sysid_v2 peripheral.
package soc_sysid_pkg;

    localparam int MAX_USER = 8;

    localparam int REG_ID        = 0;
    localparam int REG_TIMESTAMP = 1;
    localparam int REG_VERSION   = 2;
    localparam int REG_SCRATCH   = 3;
    localparam int REG_UPTIME_LO = 4;
    localparam int REG_UPTIME_HI = 5;
    localparam int REG_FEATURES  = 6;
    localparam int REG_USER_BASE = 8;

    localparam int FEAT_UPTIME_BIT   = 0;
    localparam int FEAT_NUM_USER_LSB = 8;
    localparam int FEAT_NUM_USER_W   = 4;

    function automatic logic [31:0] features_word(input logic uptime_en, input int num_user);
        logic [31:0] w;
        w = '0;
        w[FEAT_UPTIME_BIT] = uptime_en;
        w[FEAT_NUM_USER_LSB +: FEAT_NUM_USER_W] = num_user[FEAT_NUM_USER_W-1:0];
        return w;
    endfunction

endpackage

// File: rtl/soc_sysid_uptime.sv
// Free-running 64-bit uptime counter with a high-word snapshot taken on low-word reads.
module soc_sysid_uptime
    import soc_sysid_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        snap,
    output logic [31:0] count_lo,
    output logic [31:0] snap_hi
);

    logic [63:0] cnt;
    logic [31:0] snap_q;

    // A snapshot in the same cycle as a clear keeps the pre-clear high word.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt    <= '0;
            snap_q <= '0;
        end else begin
            cnt <= clear ? 64'd0 : cnt + 64'd1;
            if (snap)
                snap_q <= cnt[63:32];
            else if (clear)
                snap_q <= '0;
        end
    end

    assign count_lo = cnt[31:0];
    assign snap_hi  = snap_q;

endmodule

// File: rtl/soc_sysid_v2.sv
// System-ID peripheral: Avalon-MM slave with one-cycle registered reads.
// Optional uptime counter built when SOC_SYSID_UPTIME_EN is defined.
module soc_sysid_v2
    import soc_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID = 32'h0800_1030,
    parameter logic [31:0] TIMESTAMP = 32'h6945_0724,
    parameter logic [31:0] VERSION   = 32'h0002_0000,
    parameter int          NUM_USER  = 2,
    parameter logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] USER_WORDS = '0,
    parameter int          ADDR_W    = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    logic [31:0] up_lo;
    logic [31:0] up_hi;
    logic [31:0] scratch;
    logic [31:0] rdata;
    logic [31:0] user_arr [MAX_USER];
    logic        sel_scratch;
    logic        sel_lo;
    logic        user_hit;
    logic [2:0]  user_idx;

    assign sel_scratch = (int'(address) == REG_SCRATCH);
    assign sel_lo      = (int'(address) == REG_UPTIME_LO);

`ifdef SOC_SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;

    soc_sysid_uptime u_uptime (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (write && sel_lo),
        .snap     (read && sel_lo),
        .count_lo (up_lo),
        .snap_hi  (up_hi)
    );
`else
    localparam logic UPTIME_PRESENT = 1'b0;

    assign up_lo = '0;
    assign up_hi = '0;
`endif

    for (genvar k = 0; k < MAX_USER; k++) begin : g_user
        if (k < NUM_USER) begin : g_on
            assign user_arr[k] = USER_WORDS[k*32 +: 32];
        end else begin : g_off
            assign user_arr[k] = '0;
        end
    end

    assign user_hit = (int'(address) >= REG_USER_BASE) &&
                      (int'(address) <  REG_USER_BASE + NUM_USER);
    assign user_idx = 3'(int'(address) - REG_USER_BASE);

    always_comb begin
        rdata = '0;
        case (int'(address))
            REG_ID:        rdata = SYSTEM_ID;
            REG_TIMESTAMP: rdata = TIMESTAMP;
            REG_VERSION:   rdata = VERSION;
            REG_SCRATCH:   rdata = scratch;
            REG_UPTIME_LO: rdata = up_lo;
            REG_UPTIME_HI: rdata = up_hi;
            REG_FEATURES:  rdata = features_word(UPTIME_PRESENT, NUM_USER);
            default:       if (user_hit) rdata = user_arr[user_idx];
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scratch <= '0;
        end else if (write && sel_scratch) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) scratch[8*b +: 8] <= writedata[8*b +: 8];
        end
    end

    // rdata is taken from pre-edge state, so a colliding write is not visible here.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            readdata      <= read ? rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_soc_sysid_v2.sv
// Randomised bench for soc_sysid_v2 with a behavioural register-map model and directed literal checks.
module tb_soc_sysid_v2;

`ifdef SOC_SYSID_UPTIME_EN
    localparam bit UPT = 1'b1;
`else
    localparam bit UPT = 1'b0;
`endif
    localparam int NU = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_vec = 0;
    int n_err = 0;

    logic        started = 1'b0;
    logic        exp_v = 1'b0;
    logic [31:0] exp_d = '0;
    logic [31:0] m_scr = '0;
    logic [63:0] m_cnt = '0;
    logic [31:0] m_snap = '0;

    soc_sysid_v2 #(
        .NUM_USER   (NU),
        .USER_WORDS (64'h0000_000B_0000_000A),
        .ADDR_W     (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model_rd(input int a);
        case (a)
            0: return 32'h0800_1030;
            1: return 32'h6945_0724;
            2: return 32'h0002_0000;
            3: return m_scr;
            4: return UPT ? m_cnt[31:0] : 32'd0;
            5: return UPT ? m_snap : 32'd0;
            6: return (32'(NU) << 8) | 32'(UPT);
            8: return 32'hA;
            9: return 32'hB;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: register state as seen after each edge.
    always @(posedge clock) begin
        started = 1'b1;
        if (!reset_n) begin
            exp_v = 1'b0; exp_d = '0; m_scr = '0; m_cnt = '0; m_snap = '0;
        end else begin
            exp_v = read;
            exp_d = read ? model_rd(int'(address)) : 32'd0;
            if (UPT && read && address == 4) m_snap = m_cnt[63:32];
            if (write && address == 3)
                for (int b = 0; b < 4; b++)
                    if (byteenable[b]) m_scr[8*b +: 8] = writedata[8*b +: 8];
            if (UPT && write && address == 4) begin
                m_cnt = '0;
                if (!(read && address == 4)) m_snap = '0;
            end else begin
                m_cnt = m_cnt + 64'd1;
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            n_vec++;
            if (readdatavalid !== exp_v || readdata !== exp_d) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t: got rdv=%b data=%h, want rdv=%b data=%h",
                         $time, readdatavalid, readdata, exp_v, exp_d);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; issues one read and checks it one cycle later.
    task automatic rd(input int a, input logic [31:0] exp, input string nm);
        read = 1'b1; address = 4'(a);
        @(negedge clock);
        read = 1'b0;
        chk({nm, "_vld"}, 32'(readdatavalid), 32'd1);
        chk(nm, readdata, exp);
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        write = 1'b1; address = 4'(a); writedata = d; byteenable = be;
        @(negedge clock);
        write = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0; byteenable = '0;
        repeat (3) @(negedge clock);
        chk("reset_rdv", 32'(readdatavalid), 32'd0);
        chk("reset_data", readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        rd(0, 32'h0800_1030, "id");
        rd(1, 32'h6945_0724, "timestamp");
        rd(2, 32'h0002_0000, "version");
        @(negedge clock);
        chk("idle_rdv", 32'(readdatavalid), 32'd0);

        wr(3, 32'hDEAD_BEEF, 4'b0101);
        rd(3, 32'h00AD_00EF, "scratch_be");
        wr(3, 32'h1234_5678, 4'b1111);
        rd(3, 32'h1234_5678, "scratch_full");

        rd(8, 32'hA, "user0");
        rd(9, 32'hB, "user1");
        rd(10, 32'h0, "user_oob");
        rd(6, UPT ? 32'h0000_0201 : 32'h0000_0200, "features");
        rd(7, 32'h0, "reserved");
        rd(15, 32'h0, "unmapped");
        wr(0, 32'hFFFF_FFFF, 4'hF);
        rd(0, 32'h0800_1030, "id_ro");

`ifdef SOC_SYSID_UPTIME_EN
        wr(4, 32'h0, 4'h0);
        repeat (10) @(negedge clock);
        rd(4, 32'd10, "clr_lo");
        rd(5, 32'd0, "clr_hi");
        dut.u_uptime.cnt = 64'h0000_0000_FFFF_FFFF;
        m_cnt = 64'h0000_0000_FFFF_FFFF;
        rd(4, 32'hFFFF_FFFF, "wrap_lo");
        rd(5, 32'h0, "wrap_hi_snap");
        dut.u_uptime.cnt = 64'h0000_0000_FFFF_FFFF;
        m_cnt = 64'h0000_0000_FFFF_FFFF;
        rd(4, 32'hFFFF_FFFF, "wrap_lo2");
        rd(4, 32'h0, "carry_lo");
        rd(5, 32'h1, "carry_hi");
`else
        rd(4, 32'h0, "noup_lo");
        rd(5, 32'h0, "noup_hi");
        wr(4, 32'h0, 4'hF);
        rd(4, 32'h0, "noup_lo_wr");
`endif

        read = 1'b1; address = 4'd0;
        @(negedge clock);
        read = 1'b0; reset_n = 1'b0;
        @(negedge clock);
        chk("rst_pending_rdv", 32'(readdatavalid), 32'd0);
        chk("rst_pending_data", readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        rd(3, 32'h0, "scratch_after_rst");

        for (int i = 0; i < 800; i++) begin
            read       = 1'($urandom_range(0, 1));
            write      = ($urandom_range(0, 3) == 0);
            address    = 4'($urandom_range(0, 15));
            writedata  = $urandom;
            byteenable = 4'($urandom_range(0, 15));
            if (read && write && address == 4'd4) write = 1'b0;
            reset_n    = ($urandom_range(0, 63) != 0);
            @(negedge clock);
        end
        read = 1'b0; write = 1'b0; reset_n = 1'b1;
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
